// File: rtl/seg_scan_decoder.sv
// Monitors a multiplexed 4-digit active-low seven-segment bus and recovers the
// displayed hex digits once each select/segment pattern has been stable long enough.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int STALE_CYCLES  = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  AN,
  input  logic [6:0]  d,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic [3:0]  blank,
  output logic [3:0]  seg_err,
  output logic        frame_done
);

  localparam logic [1:0]  IDLE  = 2'd0;
  localparam logic [1:0]  TRACK = 2'd1;
  localparam logic [1:0]  HOLD  = 2'd2;

  localparam logic [7:0]  STABLE_MAX = 8'(STABLE_CYCLES);
  localparam logic [23:0] STALE_MAX  = 24'(STALE_CYCLES);
  localparam logic [23:0] STALE_LAST = 24'(STALE_CYCLES - 1);

  logic [3:0] an_reg;
  logic [6:0] d_reg;
  logic [1:0] state_reg, state_next;
  logic [3:0] ref_an_reg, ref_an_next;
  logic [6:0] ref_d_reg, ref_d_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [3:0] mask_reg;
  logic       capture;
  logic       sel_legal;
  logic [1:0] sel_idx;
  logic       same;
  logic [3:0] dec_val;
  logic       dec_ok;
  logic       dec_blank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_reg     <= 4'hF;
      d_reg      <= 7'h7F;
      state_reg  <= IDLE;
      ref_an_reg <= 4'hF;
      ref_d_reg  <= 7'h7F;
      cnt_reg    <= 8'd0;
    end else begin
      an_reg     <= AN;
      d_reg      <= d;
      state_reg  <= state_next;
      ref_an_reg <= ref_an_next;
      ref_d_reg  <= ref_d_next;
      cnt_reg    <= cnt_next;
    end
  end

  // Only a single active-low select identifies a digit; anything else is "no select".
  always_comb begin
    sel_legal = 1'b1;
    sel_idx   = 2'd0;
    case (an_reg)
      4'hE:    sel_idx = 2'd0;
      4'hD:    sel_idx = 2'd1;
      4'hB:    sel_idx = 2'd2;
      4'h7:    sel_idx = 2'd3;
      default: sel_legal = 1'b0;
    endcase
  end

  assign same = (an_reg == ref_an_reg) && (d_reg == ref_d_reg);

  always_comb begin
    dec_val   = 4'h0;
    dec_ok    = 1'b1;
    dec_blank = 1'b0;
    case (d_reg)
      7'h40: dec_val = 4'h0;
      7'h79: dec_val = 4'h1;
      7'h24: dec_val = 4'h2;
      7'h30: dec_val = 4'h3;
      7'h19: dec_val = 4'h4;
      7'h12: dec_val = 4'h5;
      7'h02: dec_val = 4'h6;
      7'h78: dec_val = 4'h7;
      7'h00: dec_val = 4'h8;
      7'h10: dec_val = 4'h9;
      7'h08: dec_val = 4'hA;
      7'h03: dec_val = 4'hB;
      7'h46: dec_val = 4'hC;
      7'h21: dec_val = 4'hD;
      7'h06: dec_val = 4'hE;
      7'h0E: dec_val = 4'hF;
      7'h7F: begin
        dec_ok    = 1'b0;
        dec_blank = 1'b1;
      end
      default: dec_ok = 1'b0;
    endcase
  end

  // Any legal sample that does not match the reference (or arrives from IDLE) restarts the count.
  always_comb begin
    state_next  = state_reg;
    ref_an_next = ref_an_reg;
    ref_d_next  = ref_d_reg;
    cnt_next    = cnt_reg;
    capture     = 1'b0;
    if (!sel_legal) begin
      state_next = IDLE;
    end else if ((state_reg == TRACK || state_reg == HOLD) && same) begin
      if (state_reg == TRACK) begin
        cnt_next = cnt_reg + 8'd1;
        if (cnt_next == STABLE_MAX) begin
          capture    = 1'b1;
          state_next = HOLD;
        end
      end
    end else begin
      ref_an_next = an_reg;
      ref_d_next  = d_reg;
      cnt_next    = 8'd1;
      if (STABLE_MAX == 8'd1) begin
        capture    = 1'b1;
        state_next = HOLD;
      end else begin
        state_next = TRACK;
      end
    end
  end

  // A full mask is visible for one cycle as frame_done while the fresh mask collects new captures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_reg <= 4'h0;
    end else begin
      mask_reg <= ((mask_reg == 4'hF) ? 4'h0 : mask_reg)
                | (capture ? (4'b0001 << sel_idx) : 4'h0);
    end
  end

  assign frame_done = (mask_reg == 4'hF);

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    logic [3:0]  val_reg;
    logic        valid_reg;
    logic        blank_reg;
    logic        err_reg;
    logic [23:0] stale_reg;
    logic        cap;

    assign cap = capture && (sel_idx == 2'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        val_reg   <= 4'h0;
        valid_reg <= 1'b0;
        blank_reg <= 1'b0;
        err_reg   <= 1'b0;
        stale_reg <= 24'd0;
      end else if (cap) begin
        stale_reg <= 24'd0;
        valid_reg <= dec_ok;
        blank_reg <= dec_blank;
        err_reg   <= !dec_ok && !dec_blank;
        if (dec_ok) val_reg <= dec_val;
      end else begin
        if (stale_reg != STALE_MAX) stale_reg <= stale_reg + 24'd1;
        if (stale_reg >= STALE_LAST) valid_reg <= 1'b0;
      end
    end

    assign digits[4*gi +: 4] = val_reg;
    assign digit_valid[gi]   = valid_reg;
    assign blank[gi]         = blank_reg;
    assign seg_err[gi]       = err_reg;
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: one instance per parameter corner
// (normal, short staleness, single-sample capture) all fed from the same bus.
module tb_seg_scan_decoder;

  logic        clk;
  logic        rst_n;
  logic [3:0]  an_in;
  logic [6:0]  d_in;

  logic [15:0] digits_a, digits_s, digits_o;
  logic [3:0]  valid_a, valid_s, valid_o;
  logic [3:0]  blank_a, blank_s, blank_o;
  logic [3:0]  err_a, err_s, err_o;
  logic        fd_a, fd_s, fd_o;

  int n_checks = 0;
  int n_errors = 0;
  int fd_cnt   = 0;
  int fd_snap  = 0;

  seg_scan_decoder #(.STABLE_CYCLES(4), .STALE_CYCLES(1000)) dut (
    .clk(clk), .rst_n(rst_n), .AN(an_in), .d(d_in),
    .digits(digits_a), .digit_valid(valid_a), .blank(blank_a),
    .seg_err(err_a), .frame_done(fd_a)
  );

  seg_scan_decoder #(.STABLE_CYCLES(4), .STALE_CYCLES(20)) dut_stale (
    .clk(clk), .rst_n(rst_n), .AN(an_in), .d(d_in),
    .digits(digits_s), .digit_valid(valid_s), .blank(blank_s),
    .seg_err(err_s), .frame_done(fd_s)
  );

  seg_scan_decoder #(.STABLE_CYCLES(1), .STALE_CYCLES(1000)) dut_one (
    .clk(clk), .rst_n(rst_n), .AN(an_in), .d(d_in),
    .digits(digits_o), .digit_valid(valid_o), .blank(blank_o),
    .seg_err(err_o), .frame_done(fd_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fd_a === 1'b1) fd_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [3:0] an, input logic [6:0] dd, input int n);
    an_in = an;
    d_in  = dd;
    $display("apply AN=%h d=%h for %0d cycles", an, dd, n);
    tick(n);
  endtask

  task automatic rotation;
    apply(4'hE, 7'h79, 8);
    apply(4'hD, 7'h24, 8);
    apply(4'hB, 7'h30, 8);
    apply(4'h7, 7'h08, 8);
  endtask

  initial begin
    rst_n = 1'b0;
    an_in = 4'hF;
    d_in  = 7'h7F;
    tick(3);
    rst_n = 1'b1;
    check_eq("reset_digits", 32'(digits_a), 32'h0);
    check_eq("reset_valid", 32'(valid_a), 32'h0);
    check_eq("reset_blank", 32'(blank_a), 32'h0);
    check_eq("reset_err", 32'(err_a), 32'h0);
    check_eq("reset_fd", 32'(fd_a), 32'h0);

    apply(4'hF, 7'h7F, 50);
    check_eq("idle_digits", 32'(digits_a), 32'h0);
    check_eq("idle_valid", 32'(valid_a), 32'h0);
    check_eq("idle_blank", 32'(blank_a), 32'h0);
    check_eq("idle_fd_count", 32'(fd_cnt), 32'd0);

    // First digit: latency of 1 input register plus STABLE_CYCLES samples.
    fd_snap = fd_cnt;
    an_in = 4'hE;
    d_in  = 7'h79;
    $display("apply AN=E d=79 with latency probes");
    tick(1);
    check_eq("one_lat_before", 32'(valid_o[0]), 32'h0);
    tick(1);
    check_eq("one_lat_at", 32'(valid_o[0]), 32'h1);
    check_eq("one_digit0", 32'(digits_o[3:0]), 32'h1);
    tick(2);
    check_eq("lat_before", 32'(valid_a[0]), 32'h0);
    tick(1);
    check_eq("lat_at", 32'(valid_a[0]), 32'h1);
    check_eq("lat_digit0", 32'(digits_a[3:0]), 32'h1);
    tick(3);
    apply(4'hD, 7'h24, 8);
    apply(4'hB, 7'h30, 8);
    apply(4'h7, 7'h08, 8);
    check_eq("scan1_digits", 32'(digits_a), 32'hA321);
    check_eq("scan1_valid", 32'(valid_a), 32'hF);
    check_eq("scan1_frames", 32'(fd_cnt - fd_snap), 32'd1);
    check_eq("one_scan_digits", 32'(digits_o), 32'hA321);
    rotation();
    check_eq("scan2_digits", 32'(digits_a), 32'hA321);
    check_eq("scan2_frames", 32'(fd_cnt - fd_snap), 32'd2);

    // Glitch: three samples of 0, one blank, then 0 must be re-counted from scratch.
    apply(4'hE, 7'h40, 3);
    apply(4'hE, 7'h7F, 1);
    apply(4'hE, 7'h40, 4);
    check_eq("glitch_no_early", 32'(digits_a[3:0]), 32'h1);
    check_eq("glitch_no_blank", 32'(blank_a[0]), 32'h0);
    tick(1);
    check_eq("glitch_capture", 32'(digits_a[3:0]), 32'h0);
    check_eq("glitch_valid", 32'(valid_a[0]), 32'h1);
    check_eq("glitch_blank", 32'(blank_a[0]), 32'h0);

    apply(4'hC, 7'h00, 20);
    check_eq("dual_sel_digits", 32'(digits_a), 32'hA320);
    check_eq("dual_sel_valid", 32'(valid_a), 32'hF);
    apply(4'hD, 7'h00, 3);
    apply(4'hF, 7'h00, 1);
    apply(4'hD, 7'h00, 4);
    check_eq("restart_no_early", 32'(digits_a[7:4]), 32'h2);
    tick(1);
    check_eq("restart_capture", 32'(digits_a[7:4]), 32'h8);

    apply(4'hB, 7'h7F, 8);
    check_eq("blank_set", 32'(blank_a[2]), 32'h1);
    check_eq("blank_valid", 32'(valid_a[2]), 32'h0);
    check_eq("blank_err", 32'(err_a[2]), 32'h0);
    check_eq("blank_digit", 32'(digits_a[11:8]), 32'h3);
    apply(4'hB, 7'h55, 8);
    check_eq("err_set", 32'(err_a[2]), 32'h1);
    check_eq("err_blank", 32'(blank_a[2]), 32'h0);
    check_eq("err_valid", 32'(valid_a[2]), 32'h0);
    check_eq("err_digit", 32'(digits_a[11:8]), 32'h3);

    // Staleness on the STALE_CYCLES=20 instance, counted from the capture edge.
    apply(4'hE, 7'h19, 5);
    check_eq("stale_capture", 32'(valid_s[0]), 32'h1);
    check_eq("stale_digit", 32'(digits_s[3:0]), 32'h4);
    apply(4'hF, 7'h19, 19);
    check_eq("stale_before", 32'(valid_s[0]), 32'h1);
    tick(1);
    check_eq("stale_expired", 32'(valid_s[0]), 32'h0);
    check_eq("stale_digit_held", 32'(digits_s[3:0]), 32'h4);
    check_eq("long_stale_valid", 32'(valid_a[0]), 32'h1);

    // Reset after two digits of a frame discards the partial mask.
    apply(4'hE, 7'h40, 8);
    apply(4'hD, 7'h79, 8);
    an_in = 4'hF;
    rst_n = 1'b0;
    $display("apply reset mid-frame");
    tick(2);
    rst_n = 1'b1;
    check_eq("midrst_digits", 32'(digits_a), 32'h0);
    check_eq("midrst_valid", 32'(valid_a), 32'h0);
    check_eq("midrst_err", 32'(err_a), 32'h0);
    check_eq("midrst_fd", 32'(fd_a), 32'h0);
    fd_snap = fd_cnt;
    apply(4'hB, 7'h30, 8);
    apply(4'h7, 7'h08, 8);
    check_eq("midrst_half_frames", 32'(fd_cnt - fd_snap), 32'd0);
    check_eq("midrst_half_digits", 32'(digits_a), 32'hA300);
    check_eq("midrst_half_valid", 32'(valid_a), 32'hC);
    apply(4'hE, 7'h40, 8);
    apply(4'hD, 7'h79, 8);
    check_eq("midrst_full_frames", 32'(fd_cnt - fd_snap), 32'd1);
    check_eq("midrst_full_digits", 32'(digits_a), 32'hA310);
    check_eq("midrst_full_valid", 32'(valid_a), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
